// File: rtl/par_width_fifo_if.sv
// Producer/consumer bundle for par_width_fifo: write side, read side, occupancy and error flags.
interface par_width_fifo_if #(
  parameter int NUM_BIT   = 8,
  parameter int DEPTH     = 8,
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 3
);
  localparam int ADDR = $clog2(DEPTH);

  logic                          init;
  logic                          wen;
  logic [PAR_WRITE*NUM_BIT-1:0]  din;
  logic                          ready;
  logic                          ren;
  logic [PAR_READ*NUM_BIT-1:0]   dout;
  logic                          valid;
  logic                          full;
  logic                          empty;
  logic [ADDR:0]                 level;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output init, wen, din, ren,
    input  ready, dout, valid, full, empty, level, overflow, underflow
  );

  modport slave (
    input  init, wen, din, ren,
    output ready, dout, valid, full, empty, level, overflow, underflow
  );
endinterface

// File: rtl/par_width_fifo.sv
// Width-converting FIFO (PAR_WRITE words in, PAR_READ words out); first-word-fall-through, a word is readable one cycle after its write.
// Backpressure: ready drops when fewer than PAR_WRITE slots remain; rejected wen/ren raise sticky overflow/underflow.
module par_width_fifo #(
  parameter int NUM_BIT   = 8,
  parameter int DEPTH     = 8,
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 3,
  parameter int ADDR      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  par_width_fifo_if.slave  bus
);

  localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] WR_MAX  = (ADDR+1)'(DEPTH - PAR_WRITE);
  localparam logic [ADDR:0] WR_STEP = (ADDR+1)'(PAR_WRITE);
  localparam logic [ADDR:0] RD_STEP = (ADDR+1)'(PAR_READ);

  logic [ADDR:0]                wp;
  logic [ADDR:0]                rp;
  logic [ADDR:0]                level;
  logic                         wr_fire;
  logic                         rd_fire;
  logic                         ovf_q;
  logic                         unf_q;
  logic [PAR_READ*NUM_BIT-1:0]  dout_c;
  logic [NUM_BIT-1:0]           mem [DEPTH];

  assign level = wp - rp;

  assign bus.level     = level;
  assign bus.ready     = (level <= WR_MAX);
  assign bus.valid     = (level >= RD_STEP);
  assign bus.full      = (level == DEPTH_L);
  assign bus.empty     = (level == '0);
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.dout      = dout_c;

  // Both sides are judged on the pre-edge level, so they can fire together.
  assign wr_fire = bus.wen && bus.ready && !bus.init;
  assign rd_fire = bus.ren && bus.valid && !bus.init;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.init) begin
      wp    <= '0;
      rp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_fire) wp <= wp + WR_STEP;
      if (rd_fire) rp <= rp + RD_STEP;
      if (bus.wen && !bus.ready) ovf_q <= 1'b1;
      if (bus.ren && !bus.valid) unf_q <= 1'b1;
    end
  end

  // Storage is not reset; stale contents stay hidden behind the dout gate.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      for (int i = 0; i < PAR_WRITE; i++)
        mem[ADDR'(wp + (ADDR+1)'(i))] <= bus.din[i*NUM_BIT +: NUM_BIT];
    end
  end

  always_comb begin
    dout_c = '0;
    if (bus.valid) begin
      for (int j = 0; j < PAR_READ; j++)
        dout_c[j*NUM_BIT +: NUM_BIT] = mem[ADDR'(rp + (ADDR+1)'(j))];
    end
  end

endmodule

// File: tb/tb_par_width_fifo.sv
// Scoreboard bench for par_width_fifo at default parameters (8-bit words, depth 8, 2 in / 3 out).
module tb_par_width_fifo;
  localparam int NUM_BIT   = 8;
  localparam int DEPTH     = 8;
  localparam int PAR_WRITE = 2;
  localparam int PAR_READ  = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [NUM_BIT-1:0] sb[$];
  logic m_ovf;
  logic m_unf;

  par_width_fifo_if #(.NUM_BIT(NUM_BIT), .DEPTH(DEPTH), .PAR_WRITE(PAR_WRITE), .PAR_READ(PAR_READ)) bus ();

  par_width_fifo #(.NUM_BIT(NUM_BIT), .DEPTH(DEPTH), .PAR_WRITE(PAR_WRITE), .PAR_READ(PAR_READ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state();
    int lvl;
    lvl = sb.size();
    chk("level",     64'(bus.level),     64'(lvl));
    chk("ready",     64'(bus.ready),     64'((DEPTH - lvl) >= PAR_WRITE));
    chk("valid",     64'(bus.valid),     64'(lvl >= PAR_READ));
    chk("full",      64'(bus.full),      64'(lvl == DEPTH));
    chk("empty",     64'(bus.empty),     64'(lvl == 0));
    chk("overflow",  64'(bus.overflow),  64'(m_ovf));
    chk("underflow", 64'(bus.underflow), 64'(m_unf));
    if (lvl < PAR_READ) chk("dout_gated", 64'(bus.dout), 64'd0);
  endtask

  // Called one step after a rising edge; returns one step after the next.
  task automatic cycle(input logic i_init, input logic w, input logic [PAR_WRITE*NUM_BIT-1:0] d,
                       input logic r);
    logic [PAR_READ*NUM_BIT-1:0] exp_dout;
    bit m_ready;
    bit m_valid;
    bus.init = i_init;
    bus.wen  = w;
    bus.din  = d;
    bus.ren  = r;
    m_ready = (DEPTH - sb.size()) >= PAR_WRITE;
    m_valid = sb.size() >= PAR_READ;
    chk_state();
    if (i_init) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (r && m_valid) begin
        for (int j = 0; j < PAR_READ; j++) exp_dout[j*NUM_BIT +: NUM_BIT] = sb.pop_front();
        chk("rd_data", 64'(bus.dout), 64'(exp_dout));
      end else if (r) begin
        m_unf = 1'b1;
      end
      if (w && m_ready) begin
        for (int i = 0; i < PAR_WRITE; i++) sb.push_back(d[i*NUM_BIT +: NUM_BIT]);
      end else if (w) begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.init = 1'b0;
    bus.wen  = 1'b0;
    bus.ren  = 1'b0;
    bus.din  = '0;
  endtask

  initial begin
    logic [7:0] nb;
    bit w;
    bit r;
    n_tests = 0;
    n_fail  = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    rst      = 1'b1;
    bus.init = 1'b0;
    bus.wen  = 1'b0;
    bus.ren  = 1'b0;
    bus.din  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty",     64'(bus.empty),     64'd1);
    chk("rst_full",      64'(bus.full),      64'd0);
    chk("rst_ready",     64'(bus.ready),     64'd1);
    chk("rst_valid",     64'(bus.valid),     64'd0);
    chk("rst_level",     64'(bus.level),     64'd0);
    chk("rst_dout",      64'(bus.dout),      64'd0);
    chk("rst_overflow",  64'(bus.overflow),  64'd0);
    chk("rst_underflow", 64'(bus.underflow), 64'd0);
    rst = 1'b0;

    // Order and width conversion
    cycle(0, 1, 16'h0201, 0);
    cycle(0, 1, 16'h0403, 0);
    chk("conv_level", 64'(bus.level), 64'd4);
    chk("conv_valid", 64'(bus.valid), 64'd1);
    chk("conv_dout",  64'(bus.dout),  64'h030201);
    cycle(0, 0, '0, 1);
    chk("conv_level_after", 64'(bus.level), 64'd1);
    chk("conv_valid_after", 64'(bus.valid), 64'd0);
    chk("conv_dout_after",  64'(bus.dout),  64'd0);

    // Fill, then a rejected write must not disturb stored data
    cycle(1, 0, '0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, {8'(8'h11 + 2*k), 8'(8'h10 + 2*k)}, 0);
    chk("fill_level", 64'(bus.level), 64'd8);
    chk("fill_full",  64'(bus.full),  64'd1);
    chk("fill_ready", 64'(bus.ready), 64'd0);
    cycle(0, 1, 16'hFFFF, 0);
    chk("ovf_flag",  64'(bus.overflow), 64'd1);
    chk("ovf_level", 64'(bus.level),    64'd8);
    chk("ovf_dout",  64'(bus.dout),     64'h121110);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);

    // Underflow at a partial level, then init beats a concurrent write
    chk("part_level", 64'(bus.level), 64'd2);
    cycle(0, 0, '0, 1);
    chk("unf_flag",  64'(bus.underflow), 64'd1);
    chk("unf_level", 64'(bus.level),     64'd2);
    cycle(1, 1, 16'hAAAA, 0);
    chk("init_level", 64'(bus.level),     64'd0);
    chk("init_ovf",   64'(bus.overflow),  64'd0);
    chk("init_unf",   64'(bus.underflow), 64'd0);

    // Simultaneous write and read at level 6
    for (int k = 0; k < 3; k++) cycle(0, 1, {8'(8'h31 + 2*k), 8'(8'h30 + 2*k)}, 0);
    chk("sim_pre_level", 64'(bus.level), 64'd6);
    cycle(0, 1, 16'h3736, 1);
    chk("sim_level", 64'(bus.level), 64'd5);
    cycle(1, 0, '0, 0);

    // Incrementing stream through many pointer wraps
    nb = 8'h00;
    for (int k = 0; k < 150; k++) begin
      w = ((DEPTH - sb.size()) >= PAR_WRITE) && ($urandom_range(0, 1) == 1);
      r = (sb.size() >= PAR_READ) && ($urandom_range(0, 1) == 1);
      cycle(0, w, {8'(nb + 8'd1), nb}, r);
      if (w) nb = nb + 8'd2;
    end
    for (int k = 0; k < 8; k++) begin
      if (sb.size() >= PAR_READ) cycle(0, 0, '0, 1);
    end
    cycle(1, 0, '0, 0);

    // Async reset between edges at level 5
    cycle(0, 1, 16'h4140, 0);
    cycle(0, 1, 16'h4342, 0);
    cycle(0, 1, 16'h4544, 1);
    cycle(0, 1, 16'h4746, 0);
    chk("arst_pre_level", 64'(bus.level), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_level", 64'(bus.level), 64'd0);
    chk("arst_valid", 64'(bus.valid), 64'd0);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_ready", 64'(bus.ready), 64'd1);
    chk("arst_dout",  64'(bus.dout),  64'd0);
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 1, 16'h5150, 0);
    cycle(0, 1, 16'h5352, 0);
    chk("post_rst_dout", 64'(bus.dout), 64'h525150);
    cycle(0, 0, '0, 1);
    chk_state();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
